ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- EX/MEM pipeline register of the 5-stage MIPS pipeline, directly downstream of the ID/EX latch and the execute datapath.
- Captures execute-stage results and the control fields MEM and WB need.
- Owns the data-memory request handshake: holds dREN/dWEN to the cache until dhit and stalls the pipeline meanwhile.
- Presents load data to the MEM/WB latch.

Parameters:
DW, 32, data/address width
RW, 5, register index width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction hit; pipeline advance enable
flush  in  1  insert bubble when advancing
ex_npc  in  DW  PC+4 of EX instruction
ex_imemload  in  DW  instruction word
ex_aluout  in  DW  ALU result / memory address
ex_wdat  in  DW  store data (forwarded rt value)
ex_wsel  in  RW  destination register index
ex_dREN, ex_dWEN, ex_RegWr, ex_MemtoReg, ex_jal, ex_halt  in  1 each  control fields
dhit  in  1  data cache hit
dmemload  in  DW  data read from cache
mem_npc, mem_imemload, mem_aluout  out  DW each  registered fields
mem_wsel  out  RW  registered destination index
mem_RegWr, mem_MemtoReg, mem_jal, mem_halt  out  1 each  registered controls
mem_rdata  out  DW  load data for MEM/WB
dmemREN, dmemWEN  out  1 each  cache requests
dmemaddr, dmemstore  out  DW each  cache address / store data
mem_stall  out  1  pipeline must hold

Behaviour:
- Reset: the reset is synchronous and active-high. With RST=1 at an edge, all registered fields, the internal load-data register and mem_rdata clear to 0, and the FSM goes to IDLE. Combinational outputs derived from them are then 0, including mem_stall.
- A reset asserted mid-ACCESS abandons the request; dmemREN/dmemWEN read 0 after that edge.
- FSM states: IDLE (no memory op held), ACCESS (request outstanding), DONE (request complete, waiting to advance).
- adv = ihit & ~mem_stall & ~mem_halt.
- On an adv edge:
  - flush=1 loads all fields to 0 (bubble).
  - Otherwise the ex_* values are loaded.
  - Next state is ACCESS if the loaded dREN|dWEN = 1, else IDLE.
- With no adv, every field and the FSM state hold, except for the ACCESS->DONE transition.
- mem_dREN/mem_dWEN are internal registered copies. A bubble carries dREN=dWEN=0.
- ACCESS:
  - dmemREN = mem_dREN and dmemWEN = mem_dWEN.
  - dmemaddr = mem_aluout and dmemstore = mem_wdat (registered copy of ex_wdat). These two are also driven in other states; the cache ignores them.
  - Requests stay asserted, unchanged, until dhit.
- mem_stall = (state==ACCESS) & ~dhit. It is combinational, so it drops in the dhit cycle.
- In an ACCESS cycle with dhit:
  - If mem_dREN=1, dmemload is written to the load-data register.
  - If ihit=1 as well, adv occurs that same edge and the next instruction loads (single-cycle hit path).
  - Otherwise the FSM goes to DONE.
- DONE: requests are 0; mem_stall=0; waits for adv.
- mem_rdata = dmemload when state==ACCESS, else the load-data register. The MEM/WB latch therefore samples valid data at the advancing edge.
- flush is ignored while mem_stall=1. An outstanding memory access is never aborted; the hazard unit holds flush until the advance.
- Halt:
  - Once the register holds halt=1, mem_halt stays 1 until reset.
  - adv is blocked, so the fields freeze.
  - A halt is never a memory op, so no requests issue.
- dhit outside ACCESS is ignored.
- There is no internal arithmetic; all fields pass through at full width.

Test Plan:
1. Reset: RST=1 for 2 cycles with ex_* nonzero and ihit=1 -> all outputs 0, mem_stall=0, dmemREN=dmemWEN=0.
2. ALU op: ex_aluout=0x00001234, ex_wsel=5, ex_RegWr=1, ihit=1 -> next cycle mem_aluout=0x00001234, mem_wsel=5, mem_RegWr=1, mem_stall=0, no dmem request.
3. Load with latency: ex_dREN=1, ex_aluout=0x80, ihit=1, then dhit low for 3 cycles ->
   - dmemREN=1, dmemaddr=0x80 and mem_stall=1 for 3 cycles.
   - 4th cycle dhit=1 with dmemload=0xDEADBEEF -> mem_rdata=0xDEADBEEF and mem_stall=0 that cycle.
   - With ihit=0 the block enters DONE: mem_rdata holds 0xDEADBEEF and dmemREN=0.
4. Store with same-cycle hit: ex_dWEN=1, ex_aluout=0x100, ex_wdat=0xCAFE -> dmemWEN=1, dmemaddr=0x100, dmemstore=0xCAFE. dhit=1 with ihit=1 and a next ALU op at ex_* -> that op loads on the same edge, dmemWEN=0 afterwards.
5. Flush:
   - flush=1 with ihit=1 in IDLE -> all fields 0 next cycle.
   - flush=1 during ACCESS with dhit=0 -> ignored; dmemREN, dmemaddr and mem_* fields are unchanged.
6. Halt and reset:
   - ex_halt=1 loaded -> mem_halt=1; a subsequent ihit=1 with new ex_* leaves all fields frozen.
   - RST=1 mid-ACCESS -> after that edge state is IDLE and dmemREN=0, mem_halt=0.

Source files
------------

// File: rtl/ex_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem_if : EX/MEM stage boundary bundle (execute inputs, MEM/WB outputs,   |
// |             data-cache request/response).      Revision 1.0                 |
// +----------------------------------------------------------------------------+
interface ex_mem_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          ihit;
  logic          flush;
  logic [DW-1:0] ex_npc;
  logic [DW-1:0] ex_imemload;
  logic [DW-1:0] ex_aluout;
  logic [DW-1:0] ex_wdat;
  logic [RW-1:0] ex_wsel;
  logic          ex_dREN;
  logic          ex_dWEN;
  logic          ex_RegWr;
  logic          ex_MemtoReg;
  logic          ex_jal;
  logic          ex_halt;
  logic          dhit;
  logic [DW-1:0] dmemload;

  logic [DW-1:0] mem_npc;
  logic [DW-1:0] mem_imemload;
  logic [DW-1:0] mem_aluout;
  logic [RW-1:0] mem_wsel;
  logic          mem_RegWr;
  logic          mem_MemtoReg;
  logic          mem_jal;
  logic          mem_halt;
  logic [DW-1:0] mem_rdata;
  logic          dmemREN;
  logic          dmemWEN;
  logic [DW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          mem_stall;

  modport master (
    output ihit, flush, ex_npc, ex_imemload, ex_aluout, ex_wdat, ex_wsel,
           ex_dREN, ex_dWEN, ex_RegWr, ex_MemtoReg, ex_jal, ex_halt,
           dhit, dmemload,
    input  mem_npc, mem_imemload, mem_aluout, mem_wsel, mem_RegWr,
           mem_MemtoReg, mem_jal, mem_halt, mem_rdata,
           dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall
  );

  modport slave (
    input  ihit, flush, ex_npc, ex_imemload, ex_aluout, ex_wdat, ex_wsel,
           ex_dREN, ex_dWEN, ex_RegWr, ex_MemtoReg, ex_jal, ex_halt,
           dhit, dmemload,
    output mem_npc, mem_imemload, mem_aluout, mem_wsel, mem_RegWr,
           mem_MemtoReg, mem_jal, mem_halt, mem_rdata,
           dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_mem : EX/MEM pipeline latch with data-cache request FSM and load-data    |
// |          capture.                              Revision 1.0                 |
// +----------------------------------------------------------------------------+
module ex_mem #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic     CLK,
  input  logic     RST,
  ex_mem_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef struct packed {
    logic [DW-1:0] npc;
    logic [DW-1:0] imemload;
    logic [DW-1:0] aluout;
    logic [DW-1:0] wdat;
    logic [RW-1:0] wsel;
    logic          dREN;
    logic          dWEN;
    logic          RegWr;
    logic          MemtoReg;
    logic          jal;
    logic          halt;
  } fields_t;

  fields_t       fld_q, fld_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          in_access;
  logic          stall;
  logic          adv;

  always_comb begin
    in_access = (state_q == ACCESS);
    stall     = in_access & ~bus.dhit;
    adv       = bus.ihit & ~stall & ~fld_q.halt;
  end

  // Pipeline fields: a flushed advance inserts an all-zero bubble.
  always_comb begin
    fld_d = fld_q;
    if (adv) begin
      if (bus.flush) begin
        fld_d = '0;
      end else begin
        fld_d.npc      = bus.ex_npc;
        fld_d.imemload = bus.ex_imemload;
        fld_d.aluout   = bus.ex_aluout;
        fld_d.wdat     = bus.ex_wdat;
        fld_d.wsel     = bus.ex_wsel;
        fld_d.dREN     = bus.ex_dREN;
        fld_d.dWEN     = bus.ex_dWEN;
        fld_d.RegWr    = bus.ex_RegWr;
        fld_d.MemtoReg = bus.ex_MemtoReg;
        fld_d.jal      = bus.ex_jal;
        fld_d.halt     = bus.ex_halt;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (in_access && bus.dhit && fld_q.dREN) begin
      rdata_d = bus.dmemload;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fld_q   <= '0;
      rdata_q <= '0;
    end else begin
      fld_q   <= fld_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a hit with ihit advances straight to the next instruction.
  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = (!bus.flush && (bus.ex_dREN || bus.ex_dWEN)) ? ACCESS : IDLE;
    end else if (in_access && bus.dhit) begin
      state_d = DONE;
    end
  end

  // FSM outputs
  always_comb begin
    bus.dmemREN      = in_access & fld_q.dREN;
    bus.dmemWEN      = in_access & fld_q.dWEN;
    bus.dmemaddr     = fld_q.aluout;
    bus.dmemstore    = fld_q.wdat;
    bus.mem_stall    = stall;
    bus.mem_rdata    = in_access ? bus.dmemload : rdata_q;
    bus.mem_npc      = fld_q.npc;
    bus.mem_imemload = fld_q.imemload;
    bus.mem_aluout   = fld_q.aluout;
    bus.mem_wsel     = fld_q.wsel;
    bus.mem_RegWr    = fld_q.RegWr;
    bus.mem_MemtoReg = fld_q.MemtoReg;
    bus.mem_jal      = fld_q.jal;
    bus.mem_halt     = fld_q.halt;
  end
endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ex_mem : directed self-checking bench for the EX/MEM latch.              |
// |                                                Revision 1.0                 |
// +----------------------------------------------------------------------------+
module tb_ex_mem;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_if #(.DW(32), .RW(5)) bus ();

  ex_mem #(.DW(32), .RW(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ihit = 0; bus.flush = 0; bus.dhit = 0; bus.dmemload = '0;
    bus.ex_npc = '0; bus.ex_imemload = '0; bus.ex_aluout = '0; bus.ex_wdat = '0;
    bus.ex_wsel = '0; bus.ex_dREN = 0; bus.ex_dWEN = 0; bus.ex_RegWr = 0;
    bus.ex_MemtoReg = 0; bus.ex_jal = 0; bus.ex_halt = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    bus.ihit = 1; bus.ex_npc = 32'h4; bus.ex_imemload = 32'h8C010080;
    bus.ex_aluout = 32'h80; bus.ex_wdat = 32'h77; bus.ex_wsel = 5'd3;
    bus.ex_dREN = 1; bus.ex_RegWr = 1; bus.ex_MemtoReg = 1; bus.ex_jal = 1;
    RST = 1;
    tick(); tick();
    bus.ihit = 0;
    RST = 0;
    #1;
    checks++;
    if ({bus.mem_npc, bus.mem_imemload, bus.mem_aluout, bus.mem_wsel, bus.mem_RegWr,
         bus.mem_MemtoReg, bus.mem_jal, bus.mem_halt, bus.mem_rdata,
         bus.dmemaddr, bus.dmemstore} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got npc=%h aluout=%h wsel=%h ctl=%b rdata=%h store=%h, want all 0",
               bus.mem_npc, bus.mem_aluout, bus.mem_wsel,
               {bus.mem_RegWr, bus.mem_MemtoReg, bus.mem_jal, bus.mem_halt},
               bus.mem_rdata, bus.dmemstore);
    end
    checks++;
    if (bus.mem_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", bus.mem_stall);
    end
    checks++;
    if ({bus.dmemREN, bus.dmemWEN} !== 2'b00) begin
      errors++; $display("FAIL reset_req: got REN/WEN=%b want 00", {bus.dmemREN, bus.dmemWEN});
    end
  endtask

  task automatic test_alu;
    clear_inputs();
    bus.ex_aluout = 32'h00001234; bus.ex_wsel = 5'd5; bus.ex_RegWr = 1; bus.ihit = 1;
    tick();
    bus.ihit = 0;
    #1;
    checks++;
    if (bus.mem_aluout !== 32'h00001234) begin
      errors++; $display("FAIL alu_aluout: got %h want 00001234", bus.mem_aluout);
    end
    checks++;
    if ({bus.mem_wsel, bus.mem_RegWr} !== {5'd5, 1'b1}) begin
      errors++; $display("FAIL alu_wsel_regwr: got wsel=%0d RegWr=%b want 5 1", bus.mem_wsel, bus.mem_RegWr);
    end
    checks++;
    if ({bus.mem_stall, bus.dmemREN, bus.dmemWEN} !== 3'b000) begin
      errors++; $display("FAIL alu_noreq: got stall/REN/WEN=%b want 000",
                         {bus.mem_stall, bus.dmemREN, bus.dmemWEN});
    end
  endtask

  task automatic test_load_latency;
    clear_inputs();
    bus.ex_dREN = 1; bus.ex_aluout = 32'h80; bus.ex_MemtoReg = 1; bus.ex_RegWr = 1;
    bus.ex_wsel = 5'd7; bus.ihit = 1;
    tick();
    // Different ex_* values to show the held request ignores them.
    bus.ex_dREN = 0; bus.ex_aluout = 32'h999;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.dmemREN, bus.dmemaddr, bus.mem_stall} !== {1'b1, 32'h80, 1'b1}) begin
        errors++; $display("FAIL load_wait%0d: got REN=%b addr=%h stall=%b want 1 00000080 1",
                           i, bus.dmemREN, bus.dmemaddr, bus.mem_stall);
      end
      tick();
    end
    bus.ihit = 0; bus.dhit = 1; bus.dmemload = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus.mem_rdata, bus.mem_stall} !== {32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL load_hit: got rdata=%h stall=%b want deadbeef 0", bus.mem_rdata, bus.mem_stall);
    end
    tick();
    bus.dhit = 0; bus.dmemload = 32'h0;
    #1;
    checks++;
    if ({bus.mem_rdata, bus.dmemREN, bus.mem_stall} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL load_done: got rdata=%h REN=%b stall=%b want deadbeef 0 0",
                         bus.mem_rdata, bus.dmemREN, bus.mem_stall);
    end
    checks++;
    if ({bus.mem_aluout, bus.mem_wsel} !== {32'h80, 5'd7}) begin
      errors++; $display("FAIL load_done_hold: got aluout=%h wsel=%0d want 00000080 7", bus.mem_aluout, bus.mem_wsel);
    end
  endtask

  task automatic test_store_hit;
    clear_inputs();
    bus.ex_dWEN = 1; bus.ex_aluout = 32'h100; bus.ex_wdat = 32'hCAFE; bus.ihit = 1;
    tick();
    bus.ihit = 0;
    #1;
    checks++;
    if ({bus.dmemWEN, bus.dmemREN, bus.dmemaddr, bus.dmemstore} !== {1'b1, 1'b0, 32'h100, 32'hCAFE}) begin
      errors++; $display("FAIL store_req: got WEN=%b REN=%b addr=%h store=%h want 1 0 00000100 0000cafe",
                         bus.dmemWEN, bus.dmemREN, bus.dmemaddr, bus.dmemstore);
    end
    clear_inputs();
    bus.dhit = 1; bus.ihit = 1; bus.ex_aluout = 32'h55; bus.ex_wsel = 5'd9; bus.ex_RegWr = 1;
    #1;
    checks++;
    if (bus.mem_stall !== 1'b0) begin
      errors++; $display("FAIL store_hit_stall: got %b want 0", bus.mem_stall);
    end
    tick();
    bus.dhit = 0; bus.ihit = 0;
    #1;
    checks++;
    if ({bus.dmemWEN, bus.mem_aluout, bus.mem_wsel, bus.mem_RegWr} !== {1'b0, 32'h55, 5'd9, 1'b1}) begin
      errors++; $display("FAIL store_next_op: got WEN=%b aluout=%h wsel=%0d RegWr=%b want 0 00000055 9 1",
                         bus.dmemWEN, bus.mem_aluout, bus.mem_wsel, bus.mem_RegWr);
    end
  endtask

  task automatic test_flush;
    clear_inputs();
    bus.ihit = 1; bus.flush = 1; bus.ex_aluout = 32'h77; bus.ex_RegWr = 1;
    bus.ex_npc = 32'h4; bus.ex_wsel = 5'd2; bus.ex_wdat = 32'h12;
    tick();
    bus.ihit = 0; bus.flush = 0;
    #1;
    checks++;
    if ({bus.mem_npc, bus.mem_imemload, bus.mem_aluout, bus.mem_wsel, bus.mem_RegWr,
         bus.mem_MemtoReg, bus.mem_jal, bus.mem_halt, bus.dmemstore} !== '0) begin
      errors++; $display("FAIL flush_bubble: got npc=%h aluout=%h wsel=%0d RegWr=%b store=%h want all 0",
                         bus.mem_npc, bus.mem_aluout, bus.mem_wsel, bus.mem_RegWr, bus.dmemstore);
    end
    clear_inputs();
    bus.ex_dREN = 1; bus.ex_aluout = 32'h200; bus.ex_wsel = 5'd3; bus.ex_RegWr = 1;
    bus.ex_npc = 32'h40; bus.ihit = 1;
    tick();
    clear_inputs();
    bus.flush = 1; bus.ihit = 1; bus.ex_aluout = 32'hABC; bus.ex_npc = 32'h44;
    tick();
    #1;
    checks++;
    if ({bus.dmemREN, bus.dmemaddr, bus.mem_wsel, bus.mem_npc, bus.mem_stall} !==
        {1'b1, 32'h200, 5'd3, 32'h40, 1'b1}) begin
      errors++; $display("FAIL flush_ignored: got REN=%b addr=%h wsel=%0d npc=%h stall=%b want 1 00000200 3 00000040 1",
                         bus.dmemREN, bus.dmemaddr, bus.mem_wsel, bus.mem_npc, bus.mem_stall);
    end
    bus.flush = 0; bus.ihit = 0; bus.dhit = 1; bus.dmemload = 32'h1111;
    tick();
    bus.dhit = 0;
  endtask

  task automatic test_halt_reset;
    clear_inputs();
    bus.ex_halt = 1; bus.ex_npc = 32'h88; bus.ihit = 1;
    tick();
    clear_inputs();
    bus.ihit = 1; bus.ex_npc = 32'h99; bus.ex_aluout = 32'hAB; bus.ex_RegWr = 1; bus.ex_dREN = 1;
    #1;
    checks++;
    if ({bus.mem_halt, bus.mem_npc} !== {1'b1, 32'h88}) begin
      errors++; $display("FAIL halt_load: got halt=%b npc=%h want 1 00000088", bus.mem_halt, bus.mem_npc);
    end
    tick(); tick();
    checks++;
    if ({bus.mem_halt, bus.mem_npc, bus.mem_aluout, bus.mem_RegWr, bus.dmemREN} !==
        {1'b1, 32'h88, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_frozen: got halt=%b npc=%h aluout=%h RegWr=%b REN=%b want 1 00000088 0 0 0",
                         bus.mem_halt, bus.mem_npc, bus.mem_aluout, bus.mem_RegWr, bus.dmemREN);
    end
    bus.ihit = 0;
    RST = 1;
    tick();
    RST = 0;
    clear_inputs();
    bus.ex_dREN = 1; bus.ex_aluout = 32'h300; bus.ihit = 1;
    tick();
    bus.ihit = 0;
    #1;
    checks++;
    if ({bus.dmemREN, bus.mem_stall} !== 2'b11) begin
      errors++; $display("FAIL rst_pre_access: got REN=%b stall=%b want 1 1", bus.dmemREN, bus.mem_stall);
    end
    RST = 1;
    tick();
    RST = 0;
    #1;
    checks++;
    if ({bus.dmemREN, bus.mem_stall, bus.mem_halt, bus.mem_aluout} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid_access: got REN=%b stall=%b halt=%b aluout=%h want 0 0 0 0",
                         bus.dmemREN, bus.mem_stall, bus.mem_halt, bus.mem_aluout);
    end
  endtask

  initial begin
    clear_inputs();
    #2;
    test_reset();
    test_alu();
    test_load_latency();
    test_store_hit();
    test_flush();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
